// File: rtl/instr_enc.sv
// instr_enc: pipelined RV32I instruction encoder (immediate-decode inverse).
// Packs opcode/register/function fields and a 32-bit signed immediate into an
// instruction word. It flags immediates that do not fit the format, misaligned
// branch/jump offsets and unknown opcodes.
// Handshake: valid/ready on input and output, with one output register and a
// 1-entry skid buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready registered, = !skid_full)
//   in_opcode..in_imm   instruction fields and signed immediate
//   out_valid/out_ready output handshake
//   out_instr, out_err  encoded word and its error flag
//   enc_cnt, err_cnt    delivered words / delivered erroneous words (wrapping)
// Build option: define INSTR_ENC_ERR_DROP_EN to drop erroneous words at
// acceptance. In that mode err_cnt counts at acceptance and out_err is 0.
module instr_enc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic             r_skid_full;
  logic [31:0]      r_skid_instr;
  logic             r_skid_err;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_enc_instr;
  logic        w_enc_err;
  logic        w_word_err;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_out_free;
  logic        w_keep;

  // Sign-extension checks: the bits above the field must all equal its sign bit.
  assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // Field packing; out-of-range immediates are still packed from truncated bits.
  always_comb begin
    w_enc_instr = 32'h0;
    w_enc_err   = 1'b0;
    case (in_opcode)
      OP_R: begin
        w_enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_I_ARITH, OP_LOAD, OP_JALR: begin
        w_enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_enc_err   = ~w_fits12;
      end
      OP_S: begin
        w_enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_enc_err   = ~w_fits12;
      end
      OP_B: begin
        w_enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
        w_enc_err   = ~w_fits13 | in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        w_enc_instr = {in_imm[31:12], in_rd, in_opcode};
        w_enc_err   = |in_imm[11:0];
      end
      OP_JAL: begin
        w_enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_enc_err   = ~w_fits21 | in_imm[0];
      end
      default: begin
        w_enc_instr = 32'h0;
        w_enc_err   = 1'b1;
      end
    endcase
  end

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_out_free = ~r_out_valid | out_ready;

`ifdef INSTR_ENC_ERR_DROP_EN
  // Erroneous words never enter the pipeline, so stored error flags stay 0.
  assign w_keep     = w_in_xfer & ~w_enc_err;
  assign w_word_err = 1'b0;
`else
  assign w_keep     = w_in_xfer;
  assign w_word_err = w_enc_err;
`endif

  // Output register + skid buffer. The skid only fills while the output is
  // stalled, and in_ready drops in the same edge so the skid never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= 32'h0;
      r_out_err    <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        // in_ready is low while the skid is full, so no new word competes here.
        r_out_valid <= 1'b1;
        r_out_instr <= r_skid_instr;
        r_out_err   <= r_skid_err;
        r_skid_full <= 1'b0;
        r_in_ready  <= 1'b1;
      end else if (w_keep) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_enc_instr;
        r_out_err   <= w_word_err;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_keep) begin
      r_skid_full  <= 1'b1;
      r_skid_instr <= w_enc_instr;
      r_skid_err   <= w_word_err;
      r_in_ready   <= 1'b0;
    end
  end

  // Delivery / error counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_out_xfer) begin
        r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      end
`ifdef INSTR_ENC_ERR_DROP_EN
      if (w_in_xfer & w_enc_err) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
`else
      if (w_out_xfer & r_out_err) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign enc_cnt   = r_enc_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Pipelined RISC-V RV32I instruction encoder; the inverse of the immediate decode path.
- Accepts an opcode, register and function fields, and a full 32-bit signed immediate, and packs them into a 32-bit instruction word.
- Checks that the immediate is representable in the selected format.
- Sits between the boot/debug program loader and instruction memory write port; valid/ready on both sides, 1-entry skid buffer.

Parameters:
- CNT_W, 16: width of the encoded-instruction and error counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept input
- in_opcode  in  7  opcode; format selected from the cpu_def.vh opcode macros
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  signed byte immediate/offset (U-type: full upper value, low 12 bits expected 0)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  range/alignment/opcode error for this word
- enc_cnt  out  CNT_W  words delivered (out_valid & out_ready)
- err_cnt  out  CNT_W  delivered words with out_err=1

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_instr=0, out_err=0, skid empty, in_ready=1, enc_cnt=0, err_cnt=0.
  - Reset mid-transfer discards the output register and skid contents with no delivery.
- Input transfer: in_valid & in_ready at a clk edge. Output transfer: out_valid & out_ready.
- Latency: input accepted at edge N appears on out_instr/out_valid after edge N (1 cycle) when the output register is free.
- Output register:
  - Loads when empty or being drained.
  - If occupied and not drained while an input is accepted, the new word goes to the skid register.
  - When the output drains and the skid is full, the skid moves to output on the same edge.
- Flow control:
  - in_ready = !skid_full. It is a registered signal with no combinational path from out_ready.
  - out_valid, out_instr and out_err are stable while out_valid & !out_ready.
  - Order is strictly preserved; no word is lost or duplicated.
- Encoding (imm = in_imm):
  - R (7'b0110011): {funct7, rs2, rs1, funct3, rd, op}. Immediate ignored; never an error.
  - I (I_TYPE_ARITH/LOAD/JALR): {imm[11:0], rs1, funct3, rd, op}. err if imm[31:11] not all equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Same range rule as I.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. err if imm[31:12] not all equal or imm[0]=1.
  - U (LUI/AUIPC): {imm[31:12], rd, op}. err if imm[11:0]≠0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. err if imm[31:20] not all equal or imm[0]=1.
  - Unlisted opcode: out_instr=0, err=1.
  - On a range/alignment error the word is still packed from the truncated bits.
- Counters:
  - Increment on output transfer; err_cnt only when out_err=1.
  - Wrap modulo 2^CNT_W without saturation.
- Simultaneous accept and drain with empty skid: output register reloads, skid stays empty, throughput 1 word/cycle.

Optional Feature:
- Macro: INSTR_ENC_ERR_DROP_EN.
- Defined:
  - Words with err=1 are never presented on the output; they are dropped at acceptance and err_cnt increments at the acceptance edge.
  - out_err is tied 0.
- Undefined: erroneous words are delivered with out_err=1 as described above.

Test Plan:
- addi x1,x0,5 (op 0010011, rd=1, f3=0, imm=5), out_ready=1 -> out_instr=0x00500093 one cycle later, err=0, enc_cnt=1.
- Each of the following -> err=0:
  - sw x2,-4(x1): imm=0xFFFFFFFC -> 0xFE20AE23.
  - beq x1,x2,+8 -> 0x00208463.
  - jal x0,-4 -> 0xFFDFF06F.
  - lui x5,0x12345000 -> 0x123452B7.
- Errors:
  - addi with imm=2048 -> out_instr=0x80000093, err=1, err_cnt=1.
  - beq with imm=3 -> err=1.
  - opcode 0x7F -> out_instr=0, err=1.
  - With INSTR_ENC_ERR_DROP_EN: none of these words is delivered, err_cnt=3.
- Backpressure: out_ready=0 for 4 cycles while 3 back-to-back inputs are offered -> in_ready falls after the 2nd accept, out_instr is held stable; after out_ready=1, words emerge in order with no gaps, third accepted afterwards.
- Full throughput: 100 consecutive inputs with out_ready=1 -> one word per cycle, enc_cnt=100.
- Reset: rst=1 for one cycle with output and skid full -> next cycle out_valid=0, in_ready=1, counters 0; the next input encodes normally.
